// File: rtl/poly_envelope_generator_if.sv
// Sample-strobe, per-voice control and amplitude bundle for the polyphonic
// envelope generator.
interface poly_envelope_generator_if #(
  parameter int VOICES  = 4,
  parameter int BITSIZE = 16
);
  logic                      sample_tick;
  logic [VOICES-1:0]         gate;
  logic [4*VOICES-1:0]       a;
  logic [4*VOICES-1:0]       d;
  logic [4*VOICES-1:0]       s;
  logic [4*VOICES-1:0]       r;
  logic [BITSIZE*VOICES-1:0] amplitude;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output sample_tick, gate, a, d, s, r,
    input  amplitude, out_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, gate, a, d, s, r,
    output amplitude, out_valid, busy, overrun
  );
endinterface

// File: rtl/poly_envelope_generator.sv
// N-voice ADSR envelope generator: one shared datapath walks the voices once
// per sample tick and publishes all amplitudes together when the pass ends.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | silent, accumulator held at 0, waiting for a gate rise
// ST_ATTACK  | ramping up by step(a) until full scale
// ST_DECAY   | ramping down by step(d) toward the sustain level
// ST_SUSTAIN | holding the (live) sustain level while gate is high
// ST_RELEASE | ramping down by step(r) toward 0 after gate fell
module poly_envelope_generator #(
  parameter int VOICES           = 4,
  parameter int BITSIZE          = 16,
  parameter int ACCUMULATOR_BITS = 26,
  parameter bit RETRIGGER_ZERO   = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  poly_envelope_generator_if.slave    env
);

  localparam int AB = ACCUMULATOR_BITS;
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [AB:0] MAX_W    = {1'b0, {AB{1'b1}}};
  localparam logic [AB:0] STEP_ONE = (AB+1)'(1) << (AB - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  logic [AB-1:0]             acc_q [VOICES];
  env_state_t                st_q  [VOICES];
  logic [VOICES-1:0]         prev_q;
  logic                      busy_q;
  logic [IW-1:0]             idx_q;
  logic [BITSIZE*VOICES-1:0] amp_q;
  logic                      out_valid_q;
  logic                      overrun_q;

  logic                      g;
  logic                      rise;
  logic [3:0]                code_a, code_d, code_s, code_r;
  logic [AB:0]               step_a, step_d, step_r;
  logic [AB:0]               sus;
  logic [AB:0]               cur;
  logic [AB:0]               sum_a;
  logic [AB:0]               rt_sum;
  logic [AB-1:0]             acc_nxt;
  env_state_t                st_nxt;
  logic [BITSIZE-2:0]        snap_hi [VOICES];
  logic [BITSIZE*VOICES-1:0] snap;

  always_comb begin
    g       = env.gate[idx_q];
    rise    = g & ~prev_q[idx_q];
    code_a  = env.a[4*idx_q +: 4];
    code_d  = env.d[4*idx_q +: 4];
    code_s  = env.s[4*idx_q +: 4];
    code_r  = env.r[4*idx_q +: 4];
    step_a  = STEP_ONE >> code_a;
    step_d  = STEP_ONE >> code_d;
    step_r  = STEP_ONE >> code_r;
    sus     = (code_s == 4'hF) ? MAX_W : {1'b0, code_s, {(AB-4){1'b0}}};
    cur     = {1'b0, acc_q[idx_q]};
    sum_a   = cur + step_a;
    // A retrigger takes its first attack step immediately, like a rise from idle.
    rt_sum  = (RETRIGGER_ZERO ? '0 : cur) + step_a;
    st_nxt  = st_q[idx_q];
    acc_nxt = acc_q[idx_q];

    unique case (st_q[idx_q])
      ST_IDLE: begin
        if (rise) begin
          st_nxt  = ST_ATTACK;
          acc_nxt = step_a[AB-1:0];
        end else begin
          acc_nxt = '0;
        end
      end
      ST_ATTACK: begin
        if (!g) begin
          st_nxt = ST_RELEASE;
        end else if (sum_a >= MAX_W) begin
          st_nxt  = ST_DECAY;
          acc_nxt = MAX_W[AB-1:0];
        end else begin
          acc_nxt = sum_a[AB-1:0];
        end
      end
      ST_DECAY: begin
        if (!g) begin
          st_nxt = ST_RELEASE;
        end else if (cur <= sus + step_d) begin
          st_nxt  = ST_SUSTAIN;
          acc_nxt = sus[AB-1:0];
        end else begin
          acc_nxt = acc_q[idx_q] - step_d[AB-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!g) st_nxt = ST_RELEASE;
        else    acc_nxt = sus[AB-1:0];
      end
      ST_RELEASE: begin
        if (rise) begin
          st_nxt  = ST_ATTACK;
          acc_nxt = (rt_sum >= MAX_W) ? MAX_W[AB-1:0] : rt_sum[AB-1:0];
        end else if (cur <= step_r) begin
          st_nxt  = ST_IDLE;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc_q[idx_q] - step_r[AB-1:0];
        end
      end
      default: begin
        st_nxt  = ST_IDLE;
        acc_nxt = '0;
      end
    endcase
  end

  // Snapshot includes the voice being written in the final cycle of the pass.
  always_comb begin
    snap = '0;
    for (int j = 0; j < VOICES; j++) begin
      snap_hi[j] = (IW'(j) == idx_q) ? acc_nxt[AB-1 -: BITSIZE-1]
                                     : acc_q[j][AB-1 -: BITSIZE-1];
      snap[j*BITSIZE +: BITSIZE] = {1'b0, snap_hi[j]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < VOICES; j++) begin
        acc_q[j] <= '0;
        st_q[j]  <= ST_IDLE;
      end
      prev_q      <= '0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      amp_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (busy_q) begin
        if (env.sample_tick) overrun_q <= 1'b1;
        acc_q[idx_q]  <= acc_nxt;
        st_q[idx_q]   <= st_nxt;
        prev_q[idx_q] <= g;
        if (idx_q == IW'(VOICES - 1)) begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          amp_q       <= snap;
          idx_q       <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end else if (env.sample_tick) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
      end
    end
  end

  assign env.amplitude = amp_q;
  assign env.out_valid = out_valid_q;
  assign env.busy      = busy_q;
  assign env.overrun   = overrun_q;

endmodule

// File: tb/tb_poly_envelope_generator.sv
// Directed bench for poly_envelope_generator: two instances (retrigger from
// current level / from zero) share the same stimulus.
module tb_poly_envelope_generator;
  localparam int V  = 4;
  localparam int B  = 16;
  localparam int AB = 26;
  localparam longint MAXV = (longint'(1) << AB) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  poly_envelope_generator_if #(.VOICES(V), .BITSIZE(B)) if0 ();
  poly_envelope_generator_if #(.VOICES(V), .BITSIZE(B)) if1 ();

  assign if1.sample_tick = if0.sample_tick;
  assign if1.gate        = if0.gate;
  assign if1.a           = if0.a;
  assign if1.d           = if0.d;
  assign if1.s           = if0.s;
  assign if1.r           = if0.r;

  poly_envelope_generator #(.VOICES(V), .BITSIZE(B), .ACCUMULATOR_BITS(AB),
                            .RETRIGGER_ZERO(1'b0))
    dut0 (.clk(clk), .reset_n(reset_n), .env(if0));
  poly_envelope_generator #(.VOICES(V), .BITSIZE(B), .ACCUMULATOR_BITS(AB),
                            .RETRIGGER_ZERO(1'b1))
    dut1 (.clk(clk), .reset_n(reset_n), .env(if1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_voice(input int v, input logic [3:0] ca, input logic [3:0] cd,
                           input logic [3:0] cs, input logic [3:0] cr);
    if0.a[4*v +: 4] = ca;
    if0.d[4*v +: 4] = cd;
    if0.s[4*v +: 4] = cs;
    if0.r[4*v +: 4] = cr;
  endtask

  task automatic run_sample(output logic [63:0] amp0, output logic [63:0] amp1);
    int n;
    n = 0;
    @(posedge clk); #1 if0.sample_tick = 1'b1;
    @(posedge clk); #1 if0.sample_tick = 1'b0;
    while (!if0.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_seen", 64'(if0.out_valid), 64'd1);
    amp0 = if0.amplitude;
    amp1 = if1.amplitude;
  endtask

  // Single-voice reference envelope
  int     m_st  [V];
  longint m_acc [V];
  bit     m_prev[V];

  function automatic void model_step(int v, bit g, int ca, int cd, int cs, int cr);
    longint sa, sd, sr, sus;
    bit rise;
    sa  = longint'(1) << (AB - 1 - ca);
    sd  = longint'(1) << (AB - 1 - cd);
    sr  = longint'(1) << (AB - 1 - cr);
    sus = (cs == 15) ? MAXV : (longint'(cs) << (AB - 4));
    rise = g && !m_prev[v];
    m_prev[v] = g;
    case (m_st[v])
      0: if (rise) begin m_st[v] = 1; m_acc[v] = m_acc[v] + sa; end
         else m_acc[v] = 0;
      1: if (!g) m_st[v] = 4;
         else if (m_acc[v] + sa >= MAXV) begin m_acc[v] = MAXV; m_st[v] = 2; end
         else m_acc[v] = m_acc[v] + sa;
      2: if (!g) m_st[v] = 4;
         else if (m_acc[v] <= sus + sd) begin m_acc[v] = sus; m_st[v] = 3; end
         else m_acc[v] = m_acc[v] - sd;
      3: if (!g) m_st[v] = 4;
         else m_acc[v] = sus;
      default:
         if (rise) begin
           m_st[v] = 1;
           m_acc[v] = m_acc[v] + sa;
           if (m_acc[v] > MAXV) m_acc[v] = MAXV;
         end else if (m_acc[v] <= sr) begin m_acc[v] = 0; m_st[v] = 0; end
         else m_acc[v] = m_acc[v] - sr;
    endcase
  endfunction

  function automatic bit gate_on(int v, int n);
    case (v)
      0: return (n < 30);
      1: return (n >= 5 && n < 40);
      2: return (n >= 10 && n < 20) || (n >= 25 && n < 35);
      default: return (n >= 2 && n < 15);
    endcase
  endfunction

  int          ca_t [V] = '{2, 3, 1, 0};
  int          cd_t [V] = '{3, 1, 2, 0};
  int          cs_t [V] = '{5, 10, 0, 15};
  int          cr_t [V] = '{4, 2, 3, 1};
  logic [15:0] adsr_exp [6] = '{16'h4000, 16'h7FFF, 16'h4000, 16'h4000, 16'h2000, 16'h0000};
  bit          adsr_gate[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] amp0, amp1;
    longint      mexp;

    if0.sample_tick = 1'b0;
    if0.gate = '0;
    if0.a = '0; if0.d = '0; if0.s = '0; if0.r = '0;
    #1;
    chk("rst_amp",     if0.amplitude,         64'd0);
    chk("rst_valid",   64'(if0.out_valid),    64'd0);
    chk("rst_busy",    64'(if0.busy),         64'd0);
    chk("rst_overrun", 64'(if0.overrun),      64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Latency: tick in cycle T, busy T+1..T+4, out_valid only T+5
    @(posedge clk); #1 if0.sample_tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) if0.sample_tick = 1'b0;
      chk($sformatf("lat_busy_%0d", k),  64'(if0.busy),      64'(k <= 4));
      chk($sformatf("lat_valid_%0d", k), 64'(if0.out_valid), 64'(k == 5));
    end
    chk("ovr_pre", 64'(if0.overrun), 64'd0);

    // Overrun: second tick at T+2 is dropped
    @(posedge clk); #1 if0.sample_tick = 1'b1;
    @(posedge clk); #1 if0.sample_tick = 1'b0;
    @(posedge clk); #1 if0.sample_tick = 1'b1;
    @(posedge clk); #1 if0.sample_tick = 1'b0;
    chk("ovr_set", 64'(if0.overrun), 64'd1);
    @(posedge clk); #1;
    chk("ovr_valid_t4", 64'(if0.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("ovr_valid_t5", 64'(if0.out_valid), 64'd1);
    @(posedge clk); #1;
    chk("ovr_valid_t6", 64'(if0.out_valid), 64'd0);
    chk("ovr_busy_t6",  64'(if0.busy),      64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("ovr_no_pass2", 64'(if0.busy), 64'd0);

    // Full ADSR on voice 0
    set_voice(0, 4'd0, 4'd0, 4'd8, 4'd1);
    for (int t = 0; t < 6; t++) begin
      if0.gate[0] = adsr_gate[t];
      run_sample(amp0, amp1);
      chk($sformatf("adsr_%0d", t + 1), amp0, {48'd0, adsr_exp[t]});
    end
    chk("ovr_sticky", 64'(if0.overrun), 64'd1);

    // Retrigger during release at 0x2000 with a=1
    for (int t = 0; t < 5; t++) begin
      if0.gate[0] = adsr_gate[t];
      run_sample(amp0, amp1);
    end
    chk("rt_pre_rz0", amp0, 64'h2000);
    chk("rt_pre_rz1", amp1, 64'h2000);
    set_voice(0, 4'd1, 4'd0, 4'd8, 4'd1);
    if0.gate[0] = 1'b1;
    run_sample(amp0, amp1);
    chk("rt_rz0", amp0, 64'h4000);
    chk("rt_rz1", amp1, 64'h2000);

    // Reset in the middle of a pass
    @(posedge clk); #1 if0.sample_tick = 1'b1;
    @(posedge clk); #1 if0.sample_tick = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_amp0",    if0.amplitude,      64'd0);
    chk("mid_rst_amp1",    if1.amplitude,      64'd0);
    chk("mid_rst_valid",   64'(if0.out_valid), 64'd0);
    chk("mid_rst_busy",    64'(if0.busy),      64'd0);
    chk("mid_rst_overrun", 64'(if0.overrun),   64'd0);
    if0.gate = '0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Independent voices against the reference model
    for (int v = 0; v < V; v++) begin
      m_st[v] = 0; m_acc[v] = 0; m_prev[v] = 1'b0;
      set_voice(v, 4'(ca_t[v]), 4'(cd_t[v]), 4'(cs_t[v]), 4'(cr_t[v]));
    end
    for (int n = 0; n < 48; n++) begin
      for (int v = 0; v < V; v++) if0.gate[v] = gate_on(v, n);
      run_sample(amp0, amp1);
      for (int v = 0; v < V; v++) begin
        model_step(v, gate_on(v, n), ca_t[v], cd_t[v], cs_t[v], cr_t[v]);
        mexp = (m_acc[v] >> (AB - B + 1)) & 64'h7FFF;
        chk($sformatf("ind_v%0d_n%0d", v, n), 64'(amp0[16*v +: 16]), 64'(mexp));
      end
      if (n == 4) chk("v3_s15_sustain", 64'(amp0[48 +: 16]), 64'h7FFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
